// File: rtl/arbitro_rr_param_if.sv
// arbitro_rr_param_if: input-FIFO / output-FIFO bus seen by the round-robin router
interface arbitro_rr_param_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 12
);
   logic [NUM_CH*DATA_W-1:0] fifo_in_data;
   logic [NUM_CH-1:0]        in_empty;
   logic [NUM_CH-1:0]        out_almost_full;
   logic [NUM_CH-1:0]        pop;
   logic [NUM_CH-1:0]        push;
   logic [DATA_W-1:0]        data_out;
   logic [NUM_CH-1:0]        grant;
   modport master (
      input  fifo_in_data, in_empty, out_almost_full,
      output pop, push, data_out, grant
   );
   modport slave (
      output fifo_in_data, in_empty, out_almost_full,
      input  pop, push, data_out, grant
   );
endinterface

// File: rtl/arbitro_rr_param.sv
// arbitro_rr_param: round-robin, quantum-limited router from NUM_CH input FIFOs to NUM_CH output FIFOs; ARB_HOL_SKIP_EN drops a grant whose head is blocked
module arbitro_rr_param #(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 12,
   parameter int QUANTUM = 4
) (
   input logic                clk,
   input logic                reset,
   arbitro_rr_param_if.master bus
);
   localparam int DEST_W = $clog2(NUM_CH);
   localparam int CNT_W  = QUANTUM > 1 ? $clog2(QUANTUM) : 1;
   typedef enum logic {IDLE, SERVE} state_t;
   state_t              state_q, state_d;
   logic [DEST_W-1:0]   ptr_q, ptr_d, g_q, g_d, sel, dest, nxt_g;
   logic [DEST_W:0]     idx;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_CH-1:0]   grant_q, grant_d;
   logic [DATA_W-1:0]   head;
   logic                found, dest_ok, blocked, xfer;
   assign head    = bus.fifo_in_data[g_q*DATA_W +: DATA_W];
   assign dest    = head[DATA_W-1 -: DEST_W];
   assign dest_ok = int'(dest) < NUM_CH;
   assign blocked = dest_ok && bus.out_almost_full[dest];
   assign xfer    = state_q == SERVE && !bus.in_empty[g_q] && !blocked;
   assign nxt_g   = g_q == DEST_W'(NUM_CH-1) ? '0 : g_q + 1'b1;
   // first non-empty channel at or after ptr, wrapping past NUM_CH-1
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = {1'b0, ptr_q} + (DEST_W+1)'(k);
         idx = idx >= (DEST_W+1)'(NUM_CH) ? idx - (DEST_W+1)'(NUM_CH) : idx;
         if (!found && !bus.in_empty[idx[DEST_W-1:0]]) begin
            found = 1'b1;
            sel   = idx[DEST_W-1:0];
         end
      end
   end
   // state register; a low reset aborts any grant in progress
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         g_q     <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         g_q     <= g_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
      end
   end
   // next state: grant in IDLE, rotate on empty input or spent quantum, hold on blocked head
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      g_d     = g_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE) begin
         if (found) begin
            state_d = SERVE;
            g_d     = sel;
            cnt_d   = '0;
         end
      end else if (bus.in_empty[g_q] || (xfer && cnt_q == CNT_W'(QUANTUM-1))) begin
         state_d = IDLE;
         ptr_d   = nxt_g;
      end else if (xfer) begin
         cnt_d = cnt_q + 1'b1;
      end
`ifdef ARB_HOL_SKIP_EN
      else begin
         state_d = IDLE;
         ptr_d   = nxt_g;
         cnt_d   = '0;
      end
`else
`endif
      grant_d = state_d == SERVE ? NUM_CH'(1) << g_d : '0;
   end
   // outputs: zero-latency transfer from the show-ahead head; out-of-range destinations are popped and dropped
   always_comb begin
      bus.pop      = reset && xfer ? NUM_CH'(1) << g_q : '0;
      bus.push     = reset && xfer && dest_ok ? NUM_CH'(1) << dest : '0;
      bus.data_out = reset && xfer ? head : '0;
      bus.grant    = grant_q;
   end
endmodule
